// File: rtl/hba_reset_pkg.sv
// Shared state encoding and sizing helper for the board reset sequencer.
// The state values are visible on seq_state, so keep them in step with any register map.
package hba_reset_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        WAIT_LOCK   = 3'd0,
        LOCK_FILTER = 3'd1,
        HOLD        = 3'd2,
        RELEASE     = 3'd3,
        RUN         = 3'd4
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hba_sync.sv
// Single-bit multi-flop synchroniser for a level signal crossing into clk.
// Clears to 0, so a freshly reset design never sees a stale lock.
module hba_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic level_sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], level};
        end
    end

    assign level_sync = chain[STAGES-1];

endmodule

// File: rtl/hba_reset_seq.sv
// Power-on and runtime reset sequencer: qualifies PLL lock, holds all domains,
// then releases them in staggered order, re-sequencing on lock loss or software request.
module hba_reset_seq
    import hba_reset_pkg::*;
#(
    parameter int NUM_DOMAINS        = 3,
    parameter int HOLD_CYCLES        = 10,
    parameter int STAGE_GAP          = 4,
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pll_locked,
    input  logic                      sw_reset_req,
    output logic [NUM_DOMAINS-1:0]    rst_out,
    output logic                      sys_ready,
    output logic [STATE_WIDTH-1:0]    seq_state,
    output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count
);

    localparam int CNT_W   = $clog2(max3(HOLD_CYCLES, STAGE_GAP, LOCK_STABLE_CYCLES)) + 1;
    localparam int STAGE_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_DOMAINS - 1);

    seq_state_e         state;
    seq_state_e         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [STAGE_W-1:0] stage;
    logic [STAGE_W-1:0] stage_next;
    logic               lock_s;
    logic               loss_event;

    hba_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk        (clk),
        .reset      (reset),
        .level      (pll_locked),
        .level_sync (lock_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            stage <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            stage <= stage_next;
        end
    end

    // Lock only counts as lost once it had been qualified (HOLD onwards).
    assign loss_event = !lock_s && (state == HOLD || state == RELEASE || state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_loss_count <= '0;
        end else if (loss_event && (lock_loss_count != '1)) begin
            lock_loss_count <= lock_loss_count + LOSS_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stage_next = stage;
        unique case (state)
            WAIT_LOCK: begin
                if (lock_s) state_next = LOCK_FILTER;
            end
            LOCK_FILTER: begin
                if (!lock_s)                state_next = WAIT_LOCK;
                else if (cnt == LOCK_LAST)  state_next = HOLD;
                else                        cnt_next   = cnt + CNT_W'(1);
            end
            HOLD: begin
                if (!lock_s)                state_next = WAIT_LOCK;
                else if (cnt == HOLD_LAST)  state_next = RELEASE;
                else                        cnt_next   = cnt + CNT_W'(1);
            end
            RELEASE: begin
                if (!lock_s)                    state_next = WAIT_LOCK;
                else if (sw_reset_req)          state_next = HOLD;
                else if (stage == LAST_STAGE)   state_next = RUN;
                else if (cnt == GAP_LAST) begin
                    stage_next = stage + STAGE_W'(1);
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s)           state_next = WAIT_LOCK;
                else if (sw_reset_req) state_next = HOLD;
            end
            default: state_next = WAIT_LOCK;
        endcase
        // Every state entry starts timing and staging from scratch.
        if (state_next != state) begin
            cnt_next   = '0;
            stage_next = '0;
        end
    end

    always_comb begin
        rst_out   = '1;
        sys_ready = 1'b0;
        unique case (state)
            RELEASE: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    rst_out[i] = (STAGE_W'(i) > stage);
                end
            end
            RUN: begin
                rst_out   = '0;
                sys_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign seq_state = state;

endmodule

// File: tb/tb_hba_reset_seq.sv
// Directed scoreboard bench for hba_reset_seq at default parameters.
// Expectations are cycle-tagged; a negedge monitor pops and compares them.
module tb_hba_reset_seq;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       pll_locked   = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic [2:0] rst_out;
    logic       sys_ready;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_count;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [2:0]  rst;
        logic        rdy;
        logic [2:0]  st;
        logic [7:0]  loss;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    hba_reset_seq dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .sw_reset_req    (sw_reset_req),
        .rst_out         (rst_out),
        .sys_ready       (sys_ready),
        .seq_state       (seq_state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input logic [2:0] rst, input logic rdy,
                             input logic [2:0] st, input logic [7:0] loss, input string name);
        exp_t e;
        e.at   = at;
        e.rst  = rst;
        e.rdy  = rdy;
        e.st   = st;
        e.loss = loss;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        vectors++;
        if (rst_out !== e.rst || sys_ready !== e.rdy || seq_state !== e.st ||
            lock_loss_count !== e.loss) begin
            miscompares++;
            $display("[TB] FAIL %s @%0d: got rst_out=%b sys_ready=%b seq_state=%0d loss=%0d, expected rst_out=%b sys_ready=%b seq_state=%0d loss=%0d",
                     name, cyc, rst_out, sys_ready, seq_state, lock_loss_count,
                     e.rst, e.rdy, e.st, e.loss);
        end
    endtask

    // Step to just after edge 'at', then drive inputs sampled by edge at+1.
    task automatic applyStimulus(input int at, input logic pll, input logic sw);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
        pll_locked   = pll;
        sw_reset_req = sw;
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string n;
        while (exp_q.size() > 0 && int'(exp_q[0].at) <= cyc) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (int'(e.at) == cyc) begin
                checkOutput(e, n);
            end else begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s: due at cycle %0d, not compared (now %0d)", n, e.at, cyc);
            end
        end
    end

    initial begin
        // Power-up: reset pulse, lock arrives at cycle 100.
        expect_at(2,   3'b111, 0, 0, 0, "por_reset");
        expect_at(50,  3'b111, 0, 0, 0, "por_wait");
        expect_at(101, 3'b111, 0, 0, 0, "por_sync_delay");
        expect_at(102, 3'b111, 0, 1, 0, "por_filter");
        expect_at(109, 3'b111, 0, 1, 0, "por_filter_end");
        expect_at(110, 3'b111, 0, 2, 0, "por_hold");
        expect_at(119, 3'b111, 0, 2, 0, "por_hold_end");
        expect_at(120, 3'b110, 0, 3, 0, "por_rel0");
        expect_at(123, 3'b110, 0, 3, 0, "por_gap");
        expect_at(124, 3'b100, 0, 3, 0, "por_rel1");
        expect_at(128, 3'b000, 0, 3, 0, "por_rel2");
        expect_at(129, 3'b000, 1, 4, 0, "por_run");
        applyStimulus(3, 0, 0);
        reset = 1'b0;
        applyStimulus(99, 1, 0);

        // Software reset from RUN, T = 140.
        expect_at(140, 3'b000, 1, 4, 0, "sw_pre");
        expect_at(141, 3'b111, 0, 2, 0, "sw_hold");
        expect_at(150, 3'b111, 0, 2, 0, "sw_hold_end");
        expect_at(151, 3'b110, 0, 3, 0, "sw_rel0");
        expect_at(155, 3'b100, 0, 3, 0, "sw_rel1");
        expect_at(159, 3'b000, 0, 3, 0, "sw_rel2");
        expect_at(160, 3'b000, 1, 4, 0, "sw_run");
        applyStimulus(140, 1, 1);
        applyStimulus(141, 1, 0);

        // Lock loss in RUN, then relock.
        expect_at(172, 3'b000, 1, 4, 0, "loss_pre");
        expect_at(173, 3'b111, 0, 0, 1, "loss_wait");
        expect_at(183, 3'b111, 0, 1, 1, "loss_refilter");
        expect_at(191, 3'b111, 0, 2, 1, "loss_rehold");
        expect_at(201, 3'b110, 0, 3, 1, "loss_rerel");
        expect_at(210, 3'b000, 1, 4, 1, "loss_rerun");
        applyStimulus(170, 0, 0);
        applyStimulus(180, 1, 0);

        // One-cycle glitch during LOCK_FILTER is not a counted loss.
        expect_at(222, 3'b000, 1, 4, 1, "glitch_pre");
        expect_at(223, 3'b111, 0, 0, 2, "glitch_loss2");
        expect_at(233, 3'b111, 0, 1, 2, "glitch_filter");
        expect_at(237, 3'b111, 0, 1, 2, "glitch_filter_b");
        expect_at(238, 3'b111, 0, 0, 2, "glitch_back_wait");
        expect_at(239, 3'b111, 0, 1, 2, "glitch_refilter");
        expect_at(247, 3'b111, 0, 2, 2, "glitch_hold");
        expect_at(256, 3'b111, 0, 2, 2, "glitch_hold_end");
        expect_at(257, 3'b110, 0, 3, 2, "glitch_rel0");
        expect_at(265, 3'b000, 0, 3, 2, "glitch_rel2");
        expect_at(266, 3'b000, 1, 4, 2, "glitch_run");
        applyStimulus(220, 0, 0);
        applyStimulus(230, 1, 0);
        applyStimulus(235, 0, 0);
        applyStimulus(236, 1, 0);

        // Lock loss and software request on the same edge: loss wins.
        expect_at(272, 3'b000, 1, 4, 2, "both_pre");
        expect_at(273, 3'b111, 0, 0, 3, "both_wait");
        expect_at(283, 3'b111, 0, 1, 3, "both_filter");
        expect_at(291, 3'b111, 0, 2, 3, "both_hold");
        expect_at(301, 3'b110, 0, 3, 3, "both_rel0");
        applyStimulus(270, 0, 0);
        applyStimulus(272, 0, 1);
        applyStimulus(273, 0, 0);
        applyStimulus(280, 1, 0);

        // Async reset mid-RELEASE, checked before the next clock edge.
        expect_at(302, 3'b111, 0, 0, 0, "areset_now");
        expect_at(304, 3'b111, 0, 0, 0, "areset_held");
        expect_at(308, 3'b111, 0, 1, 0, "areset_filter");
        expect_at(316, 3'b111, 0, 2, 0, "areset_hold");
        expect_at(326, 3'b110, 0, 3, 0, "areset_rel0");
        expect_at(330, 3'b100, 0, 3, 0, "areset_rel1");
        expect_at(334, 3'b000, 0, 3, 0, "areset_rel2");
        expect_at(335, 3'b000, 1, 4, 0, "areset_run");
        applyStimulus(302, 1, 0);
        #1;
        reset = 1'b1;
        applyStimulus(305, 1, 0);
        reset = 1'b0;

        // 300 lock losses, one every 12 cycles, saturate the 8-bit counter.
        expect_at(342,  3'b111, 0, 0, 1,   "sat_first");
        expect_at(3390, 3'b111, 0, 0, 255, "sat_255th");
        expect_at(3402, 3'b111, 0, 0, 255, "sat_256th");
        expect_at(3930, 3'b111, 0, 0, 255, "sat_300th");
        expect_at(3957, 3'b000, 0, 3, 255, "sat_rel2");
        expect_at(3958, 3'b000, 1, 4, 255, "sat_run");
        for (int k = 0; k < 300; k++) begin
            applyStimulus(339 + 12 * k, 0, 0);
            applyStimulus(340 + 12 * k, 1, 0);
        end

        applyStimulus(3965, 1, 0);
        while (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: due at cycle %0d, never compared", name_q[0], exp_q[0].at);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
